// File: rtl/elapsed_timer_pkg.sv
// elapsed_timer_pkg: shared types and helpers for the elapsed-time counter.
//   state_t   : controller state encoding (IDLE, RUN, HOLD, DONE)
//   pre_width : bit width needed to hold prescaler phases 0 .. DVSR-1
package elapsed_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // DVSR is at least 2, so the result is never below 1 bit.
  function automatic int pre_width(input int dvsr);
    return (dvsr <= 2) ? 1 : $clog2(dvsr);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of a cascaded decimal counter.
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   clr       : synchronous clear to 0
//   inc_in    : advance this digit by one (carry from the lower decade)
//   digit     : current decimal value 0..9
//   carry_out : combinational; high when this digit rolls 9 -> 0
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == 4'd9);

  always_ff @(posedge clk) begin
    if (reset || clr)
      digit <= 4'd0;
    else if (inc_in)
      digit <= carry_out ? 4'd0 : digit + 4'd1;
  end

endmodule

// File: rtl/elapsed_timer.sv
// elapsed_timer: prescaled elapsed-time counter with run/hold/resume,
// lap capture, programmable timeout and saturate-or-wrap overflow.
//
// Optional build macro: ELAPSED_TIMER_BCD_EN adds a decimal mirror of the
// count on port bcd (4*BCD_DIGITS bits).
//
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   clr       : synchronous clear to IDLE (count, prescaler, ovf, lap_count)
//   start     : level; start or resume counting
//   stop      : level; pause counting (wins over start)
//   lap       : capture count into lap_count
//   limit     : timeout value, 0 disables timeout
//   count     : elapsed ticks
//   lap_count : last captured count
//   running   : high while state is RUN
//   tick      : one-cycle base tick, RUN only
//   timeout   : one-cycle pulse when count first shows limit
//   ovf       : sticky overflow flag
//   bcd       : decimal count (only with ELAPSED_TIMER_BCD_EN)
module elapsed_timer
  import elapsed_timer_pkg::*;
#(
  parameter int DVSR       = 100000,
  parameter int CNT_W      = 14,
  parameter int WRAP       = 0,
  parameter int BCD_DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             lap,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap_count,
  output logic             running,
  output logic             tick,
  output logic             timeout,
`ifdef ELAPSED_TIMER_BCD_EN
  output logic [4*BCD_DIGITS-1:0] bcd,
`endif
  output logic             ovf
);

  localparam int               PRE_W    = pre_width(DVSR);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DVSR - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] count_next;
  logic             at_max;
  logic             moved;
  logic             hit;

  assign tick   = (state == RUN) && (pre == PRE_LAST);
  assign at_max = (count == CNT_MAX);

  // Value the count takes if this cycle's tick lands.
  always_comb begin
    count_next = count;
    if (tick) begin
      if (!at_max)
        count_next = count + 1'b1;
      else if (WRAP != 0)
        count_next = '0;
    end
  end

  // A saturated count that merely holds has not "reached" anything, so it
  // must not raise timeout again.
  assign moved = tick && !(at_max && (WRAP == 0));
  assign hit   = moved && (limit != '0) && (count_next == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      pre       <= '0;
      count     <= '0;
      lap_count <= '0;
      timeout   <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      running   <= 1'b0;
      pre       <= '0;
      count     <= '0;
      lap_count <= '0;
      timeout   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      timeout <= 1'b0;
      // lap samples the registered count, i.e. the pre-tick value.
      if (lap)
        lap_count <= count;

      case (state)
        IDLE, HOLD: begin
          // Prescaler phase is left untouched so a resume continues mid-tick.
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          pre   <= tick ? '0 : pre + 1'b1;
          count <= count_next;
          if (tick && at_max)
            ovf <= 1'b1;
          // Reaching the limit ends the run even if stop arrives together.
          if (hit) begin
            state   <= DONE;
            running <= 1'b0;
            timeout <= 1'b1;
          end else if (stop) begin
            state   <= HOLD;
            running <= 1'b0;
          end
        end
        DONE: begin
          // Frozen until clr or reset.
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef ELAPSED_TIMER_BCD_EN
  // Decimal mirror advances only on real increments: not on saturate-hold
  // and not on a binary wrap.
  logic                  advance;
  logic [BCD_DIGITS:0]   carry;

  assign advance  = tick && !at_max;
  assign carry[0] = advance;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_bcd
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .inc_in    (carry[d]),
      .digit     (bcd[4*d +: 4]),
      .carry_out (carry[d+1])
    );
  end
`endif

endmodule

// File: tb/tb_elapsed_timer.sv
// tb_elapsed_timer: drives a saturating and a wrapping elapsed_timer with the
// same stimulus and checks both against an elapsed-run-cycle reference model.
module tb_elapsed_timer;

  localparam int DV   = 4;
  localparam int CW   = 4;
  localparam int BD   = 2;
  localparam int MAXV = (1 << CW) - 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset, clr, start, stop, lap;
  logic [CW-1:0] limit;

  logic [CW-1:0] count [2];
  logic [CW-1:0] lap_count [2];
  logic running [2], tick [2], timeout [2], ovf [2];
`ifdef ELAPSED_TIMER_BCD_EN
  logic [4*BD-1:0] bcd [2];
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: the count is a pure function of cycles spent in RUN.
  int m_state [2];
  int m_run   [2];
  int m_lap   [2];
  int m_tmo   [2];

  always #5 clk = ~clk;

  for (genvar w = 0; w < 2; w++) begin : g_dut
    elapsed_timer #(.DVSR(DV), .CNT_W(CW), .WRAP(w), .BCD_DIGITS(BD)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .start     (start),
      .stop      (stop),
      .lap       (lap),
      .limit     (limit),
      .count     (count[w]),
      .lap_count (lap_count[w]),
      .running   (running[w]),
      .tick      (tick[w]),
      .timeout   (timeout[w]),
`ifdef ELAPSED_TIMER_BCD_EN
      .bcd       (bcd[w]),
`endif
      .ovf       (ovf[w])
    );
  end

  function automatic int mcnt(int w, int t);
    if (w != 0) return t % (MAXV + 1);
    return (t > MAXV) ? MAXV : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check tick before the edge, advance model, check after the edge.
  task automatic step();
    int ns [2], nr [2], nl [2], nt [2];
    for (int w = 0; w < 2; w++) begin
      int t, cur;
      t   = m_run[w] / DV;
      cur = mcnt(w, t);
      chk(w ? "tick_w" : "tick_s", 32'(tick[w]),
          32'((m_state[w] == S_RUN) && (m_run[w] % DV == DV - 1)));
      ns[w] = m_state[w]; nr[w] = m_run[w]; nl[w] = m_lap[w]; nt[w] = 0;
      if (reset || clr) begin
        ns[w] = S_IDLE; nr[w] = 0; nl[w] = 0;
      end else begin
        if (lap) nl[w] = cur;
        if (m_state[w] == S_IDLE || m_state[w] == S_HOLD) begin
          if (start && !stop) ns[w] = S_RUN;
        end else if (m_state[w] == S_RUN) begin
          nr[w] = m_run[w] + 1;
          if (nr[w] % DV == 0 && (w != 0 || t < MAXV) && limit != 0 &&
              mcnt(w, t + 1) == int'(limit)) begin
            ns[w] = S_DONE; nt[w] = 1;
          end
          if (ns[w] != S_DONE && stop) ns[w] = S_HOLD;
        end
      end
    end
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      int t;
      m_state[w] = ns[w]; m_run[w] = nr[w]; m_lap[w] = nl[w]; m_tmo[w] = nt[w];
      t = m_run[w] / DV;
      chk(w ? "count_w"   : "count_s",   32'(count[w]),     32'(mcnt(w, t)));
      chk(w ? "lap_w"     : "lap_s",     32'(lap_count[w]), 32'(m_lap[w]));
      chk(w ? "running_w" : "running_s", 32'(running[w]),   32'(m_state[w] == S_RUN));
      chk(w ? "timeout_w" : "timeout_s", 32'(timeout[w]),   32'(m_tmo[w]));
      chk(w ? "ovf_w"     : "ovf_s",     32'(ovf[w]),       32'(t > MAXV));
`ifdef ELAPSED_TIMER_BCD_EN
      begin
        int v;
        v = (w != 0) ? t - t / (MAXV + 1) : ((t > MAXV) ? MAXV : t);
        v = v % 100;
        chk(w ? "bcd_w" : "bcd_s", 32'(bcd[w]), 32'(((v / 10) << 4) | (v % 10)));
      end
`endif
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; clr = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0; limit = '0;
    for (int w = 0; w < 2; w++) begin
      m_state[w] = S_IDLE; m_run[w] = 0; m_lap[w] = 0; m_tmo[w] = 0;
    end
    steps(2);
    reset = 1'b0;

    // 1: ticks every DV cycles after the RUN entry edge.
    start = 1'b1; step();
    steps(12);
    chk("t1_count", 32'(count[0]), 32'd3);
    chk("t1_running", 32'(running[0]), 32'd1);
    start = 1'b0;

    // 2: hold keeps prescaler phase; resume gives exactly one more tick.
    do_clr();
    start = 1'b1; step(); start = 1'b0;
    steps(2);
    stop = 1'b1; step(); stop = 1'b0;
    steps(10);
    chk("t2_hold_count", 32'(count[0]), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("t2_resume_count", 32'(count[0]), 32'd0);
    step();
    chk("t2_tick_count", 32'(count[0]), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;

    // 3: timeout at limit, DONE ignores start, clr returns to IDLE.
    do_clr();
    limit = 4'd5; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (timeout[0] === 1'b1) seen = 1'b1;
    end
    chk("t3_timeout_seen", 32'(seen), 32'd1);
    chk("t3_count", 32'(count[0]), 32'd5);
    chk("t3_running", 32'(running[0]), 32'd0);
    steps(20);
    chk("t3_done_count", 32'(count[0]), 32'd5);
    start = 1'b0;
    do_clr();
    chk("t3_clr_count", 32'(count[0]), 32'd0);

    // 4: saturate vs wrap, ovf sticky until clr.
    limit = '0;
    start = 1'b1; step(); start = 1'b0;
    steps(64);
    chk("t4_wrap_zero", 32'(count[1]), 32'd0);
    chk("t4_wrap_ovf", 32'(ovf[1]), 32'd1);
    steps(16);
    chk("t4_sat_count", 32'(count[0]), 32'd15);
    chk("t4_sat_ovf", 32'(ovf[0]), 32'd1);
    do_clr();
    chk("t4_clr_ovf", 32'(ovf[0]), 32'd0);

    // 5: clr beats start; stop beats start in RUN; lap on a tick cycle.
    clr = 1'b1; start = 1'b1; step(); clr = 1'b0;
    chk("t5_clr_start", 32'(running[0]), 32'd0);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("t5_stop_start", 32'(running[0]), 32'd0);
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (m_state[0] == S_RUN && m_run[0] % DV == DV - 1 && mcnt(0, m_run[0] / DV) == 7) begin
        lap = 1'b1; step(); lap = 1'b0; seen = 1'b1;
      end else step();
    end
    chk("t5_lap_found", 32'(seen), 32'd1);
    chk("t5_lap_count", 32'(lap_count[0]), 32'd7);
    chk("t5_count", 32'(count[0]), 32'd8);

    // Randomized phase against the model.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 9) < 3);
      stop  = ($urandom_range(0, 9) == 0);
      lap   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) limit = CW'($urandom_range(0, MAXV));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
